// File: rtl/riscv_mult_serial_pkg.sv
// Shared definitions for the serial RV32M multiplier: opcode encodings and FSM states.
package riscv_mult_serial_pkg;

   localparam logic [1:0] MUL_OP_MUL    = 2'd0;
   localparam logic [1:0] MUL_OP_MULH   = 2'd1;
   localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
   localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      FINISH
   } mult_state_e;

endpackage

// File: rtl/riscv_mult_serial_if.sv
// Operand/result handshake bundle between the EX stage (master) and the serial multiplier (slave).
interface riscv_mult_serial_if #(
   parameter int unsigned C_WIDTH = 32
);
   logic [C_WIDTH-1:0] OpA_DI;
   logic [C_WIDTH-1:0] OpB_DI;
   logic [1:0]         OpCode_SI;
   logic               InVld_SI;
   logic               InRdy_SO;
   logic               OutRdy_SI;
   logic               OutVld_SO;
   logic [C_WIDTH-1:0] Res_DO;

   modport master (
      output OpA_DI, OpB_DI, OpCode_SI, InVld_SI, OutRdy_SI,
      input  InRdy_SO, OutVld_SO, Res_DO
   );

   modport slave (
      input  OpA_DI, OpB_DI, OpCode_SI, InVld_SI, OutRdy_SI,
      output InRdy_SO, OutVld_SO, Res_DO
   );
endinterface

// File: rtl/riscv_mult_serial.sv
// Serial shift-add multiplier for MUL/MULH/MULHSU/MULHU: multiplies magnitudes one
// multiplier bit per cycle, then applies the sign to the full 2W-bit product.
module riscv_mult_serial
   import riscv_mult_serial_pkg::*;
#(
   parameter int unsigned C_WIDTH     = 32,
   parameter int unsigned C_LOG_WIDTH = 6
) (
   input logic                Clk_CI,
   input logic                Rst_RI,
   riscv_mult_serial_if.slave Bus_S
);

   if (C_LOG_WIDTH != $clog2(C_WIDTH + 1)) begin : g_log_width_chk
      $error("C_LOG_WIDTH must equal $clog2(C_WIDTH+1)");
   end

   localparam logic [C_LOG_WIDTH-1:0] CNT_INIT = C_LOG_WIDTH'(C_WIDTH - 1);
   localparam logic [C_LOG_WIDTH-1:0] CNT_ONE  = C_LOG_WIDTH'(1);

   mult_state_e              state_q, state_d;
   logic [C_LOG_WIDTH-1:0]   cnt_q, cnt_d;
   logic [C_WIDTH-1:0]       amag_q, amag_d;
   logic [C_WIDTH-1:0]       phi_q, phi_d;
   logic [C_WIDTH-1:0]       plo_q, plo_d;
   logic                     neg_q, neg_d;
   logic                     hisel_q, hisel_d;
   logic [C_WIDTH-1:0]       res_q, res_d;

   logic                     a_sgn, b_sgn;
   logic [C_WIDTH:0]         sum;
   logic [2*C_WIDTH-1:0]     prod_raw;
   logic [2*C_WIDTH-1:0]     prod_fix;

   // State and datapath registers, synchronous reset clears everything
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         amag_q  <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         neg_q   <= 1'b0;
         hisel_q <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         amag_q  <= amag_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         neg_q   <= neg_d;
         hisel_q <= hisel_d;
         res_q   <= res_d;
      end
   end

   // Next-state, shift-add step and sign fix-up
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      amag_d  = amag_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      neg_d   = neg_q;
      hisel_d = hisel_q;
      res_d   = res_q;

      a_sgn = ((Bus_S.OpCode_SI == MUL_OP_MULH) || (Bus_S.OpCode_SI == MUL_OP_MULHSU))
              & Bus_S.OpA_DI[C_WIDTH-1];
      b_sgn = (Bus_S.OpCode_SI == MUL_OP_MULH) & Bus_S.OpB_DI[C_WIDTH-1];

      sum      = {1'b0, phi_q} + (plo_q[0] ? {1'b0, amag_q} : '0);
      prod_raw = {sum, plo_q[C_WIDTH-1:1]};
      // Fix-up negator kept separate from the load-time magnitude negation so the
      // last step's adder and the 2W-bit negate do not sit behind an operand mux.
      prod_fix = neg_q ? -prod_raw : prod_raw;

      unique case (state_q)
         IDLE: begin
            if (Bus_S.InVld_SI) begin
               amag_d  = a_sgn ? -Bus_S.OpA_DI : Bus_S.OpA_DI;
               plo_d   = b_sgn ? -Bus_S.OpB_DI : Bus_S.OpB_DI;
               phi_d   = '0;
               neg_d   = a_sgn ^ b_sgn;
               hisel_d = (Bus_S.OpCode_SI != MUL_OP_MUL);
               cnt_d   = CNT_INIT;
               state_d = MULT;
            end
         end
         MULT: begin
            phi_d = prod_raw[2*C_WIDTH-1:C_WIDTH];
            plo_d = prod_raw[C_WIDTH-1:0];
            cnt_d = cnt_q - CNT_ONE;
            // The result register captures the product including this final step
            if (cnt_q == '0) begin
               res_d   = hisel_q ? prod_fix[2*C_WIDTH-1:C_WIDTH] : prod_fix[C_WIDTH-1:0];
               state_d = FINISH;
            end
         end
         FINISH: begin
            if (Bus_S.OutRdy_SI) begin
               res_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Bus_S.InRdy_SO  = (state_q == IDLE);
   assign Bus_S.OutVld_SO = (state_q == FINISH);
   assign Bus_S.Res_DO    = res_q;

endmodule
